// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: shared types, defaults and flag helpers for the bit-serial ALU units
package serial_alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    // Subtraction overflows when the operand signs differ and the result sign differs from the minuend
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (d_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// full_subtractor: combinational 1-bit a - b - bin cell
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin with borrow, zero and overflow flags
module serial_subtractor
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             z,
    output logic             v
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, nstate;
    logic [WIDTH-1:0] ra, rb, dnext;
    logic [CW-1:0]    cnt;
    logic             br, d, brn, last;

    full_subtractor u_fs (
        .a   (ra[0]),
        .b   (rb[0]),
        .bin (br),
        .d   (d),
        .bout(brn)
    );

    assign last      = cnt == CW'(WIDTH - 1);
    assign dnext     = {d, diff[WIDTH-1:1]};
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        nstate = state;
        nstate = state == IDLE ? (in_valid ? SUB : IDLE) :
                 state == SUB  ? (last ? DONE : SUB) :
                                 (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nstate;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            diff <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            bout <= 1'b0;
            z    <= 1'b0;
            v    <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            ra  <= a;
            rb  <= b;
            br  <= bin;
            cnt <= '0;
        end else if (state == SUB) begin
            ra   <= ra >> 1;
            rb   <= rb >> 1;
            diff <= dnext;
            br   <= brn;
            cnt  <= cnt + CW'(1);
            // On the last bit ra[0]/rb[0] hold the original sign bits and d is the result sign
            if (last) begin
                bout <= brn;
                z    <= dnext == '0;
                v    <= sub_ovf(ra[0], rb[0], d);
            end
        end
    end

endmodule
